spi_buffer: RTL and testbench

- SPI slave receive buffer (mode 0: sample on rising CLK, MSB first) for an SD-card-style serial link.
- Shifts DI in while CS is low and publishes each completed WIDTH-bit word on Buffer.
- Pulses Changed for one CLK cycle per completed word.
- Sits between the SPI pins and the command/data decoder; CLK is the SPI clock itself.

---
 rtl/spi_buffer.sv | 82 ++++++++
 tb/tb_spi_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/spi_buffer.sv
// SPI mode-0 slave receive buffer: shifts DI while CS is low and publishes each WIDTH-bit word.
// Optional build macro SPI_BUFFER_FRAME_CNT_EN adds ByteCnt, a per-frame count of completed words.
module spi_buffer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             DI,
  output logic [WIDTH-1:0] Buffer,
`ifdef SPI_BUFFER_FRAME_CNT_EN
  output logic             Changed,
  output logic [7:0]       ByteCnt
`else
  output logic             Changed
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-2:0] shift_r;
  logic [WIDTH-2:0] shift_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [WIDTH-1:0] word_s;
  logic             last_s;
  logic             load_s;

  // Next-state for the shift register and bit counter; CS high discards any partial word.
  always_comb begin
    shift_next_s = '0;
    cnt_next_s   = '0;
    word_s       = MSB_FIRST ? {shift_r, DI} : {DI, shift_r};
    last_s       = (cnt_r == LAST_BIT);
    load_s       = 1'b0;
    if (CS) begin
      shift_next_s = '0;
      cnt_next_s   = '0;
    end else if (last_s) begin
      // Word complete: clear so the next bit starts a fresh word with no gap.
      load_s       = 1'b1;
      shift_next_s = '0;
      cnt_next_s   = '0;
    end else begin
      shift_next_s = MSB_FIRST ? word_s[WIDTH-2:0] : word_s[WIDTH-1:1];
      cnt_next_s   = cnt_r + CNT_W'(1);
    end
  end

  // Receive state and registered outputs; reset has priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_r <= '0;
      cnt_r   <= '0;
      Buffer  <= '0;
      Changed <= 1'b0;
    end else begin
      shift_r <= shift_next_s;
      cnt_r   <= cnt_next_s;
      Changed <= load_s;
      if (load_s) begin
        Buffer <= word_s;
      end
    end
  end

`ifdef SPI_BUFFER_FRAME_CNT_EN
  // Per-frame completed-word counter, updated on the same edge as Buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ByteCnt <= 8'd0;
    end else if (CS) begin
      ByteCnt <= 8'd0;
    end else if (load_s) begin
      ByteCnt <= ByteCnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_buffer.sv
// Scoreboard bench for spi_buffer: stimulus pushes expected words, a monitor pops them on Changed.
module tb_spi_buffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CS  = 1'b1;
  logic       DI  = 1'b0;
  logic [7:0] Buffer;
  logic       Changed;
`ifdef SPI_BUFFER_FRAME_CNT_EN
  logic [7:0] ByteCnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  spi_buffer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CS     (CS),
    .DI     (DI),
    .Buffer (Buffer),
`ifdef SPI_BUFFER_FRAME_CNT_EN
    .Changed(Changed),
    .ByteCnt(ByteCnt)
`else
    .Changed(Changed)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic cs, input logic di);
    CS = cs;
    DI = di;
    @(negedge CLK);
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] cnt);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back({w, cnt});
      send_bit(1'b0, w[7-i]);
    end
  endtask

  // Monitor: every Changed pulse must match the oldest expected word.
  always @(posedge CLK) begin
    logic [15:0] exp;
    #1;
    if (Changed === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL changed_unexpected actual=1 expected=0 buffer=%02h", Buffer);
      end else begin
        exp = exp_q.pop_front();
        if (Buffer !== exp[15:8]) begin
          errors++;
          $display("FAIL word_buffer actual=%02h expected=%02h", Buffer, exp[15:8]);
        end
`ifdef SPI_BUFFER_FRAME_CNT_EN
        checks++;
        if (ByteCnt !== exp[7:0]) begin
          errors++;
          $display("FAIL word_bytecnt actual=%0d expected=%0d", ByteCnt, exp[7:0]);
        end
`endif
      end
    end
  end

  initial begin
    RST = 1'b1;
    CS  = 1'b1;
    DI  = 1'b1;
    repeat (3) @(negedge CLK);
    check8("reset_buffer", Buffer, 8'h00);
    check8("reset_changed", {7'd0, Changed}, 8'h00);
`ifdef SPI_BUFFER_FRAME_CNT_EN
    check8("reset_bytecnt", ByteCnt, 8'h00);
`endif
    RST = 1'b0;

    // Power-up preamble: CS high, DI high, no effect.
    for (int i = 0; i < 74; i++) send_bit(1'b1, 1'b1);
    check8("preamble_buffer", Buffer, 8'h00);

    send_word(8'h7A, 8'd1);
    send_word(8'h80, 8'd2);

    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(8'h0C, 8'd1);
    send_word(8'h40, 8'd2);

    // One stray bit, then abort the frame.
    send_bit(1'b0, 1'b1);
    check8("partial_buffer", Buffer, 8'h40);
    check8("partial_changed", {7'd0, Changed}, 8'h00);
    send_bit(1'b1, 1'b0);
    send_word(8'hFF, 8'd1);

    // Reset after 4 bits of a word.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    RST = 1'b1;
    send_bit(1'b0, 1'b0);
    check8("midrst_buffer", Buffer, 8'h00);
    check8("midrst_changed", {7'd0, Changed}, 8'h00);
`ifdef SPI_BUFFER_FRAME_CNT_EN
    check8("midrst_bytecnt", ByteCnt, 8'h00);
`endif
    RST = 1'b0;
    send_word(8'hA5, 8'd1);
    send_bit(1'b1, 1'b0);
    check8("final_buffer", Buffer, 8'hA5);

    repeat (4) send_bit(1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_changed actual=%0d expected=0 pending words", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
